// File: rtl/fifo_scoreboard.sv
// Passive checker that shadows a ready/valid FIFO and reports reset, protocol and data errors.
// Optional saturating error counter is built when FIFO_SCOREBOARD_ERR_CNT_EN is defined.
module fifo_scoreboard #(
  parameter int unsigned WIDTH_P = 8,
  parameter int unsigned CAP_P   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               ready_o,
  input  logic               valid_o,
  input  logic [WIDTH_P-1:0] data_o,
  input  logic               yumi_i,
  input  logic               cov_clr,
  output logic               res_err,
  output logic               proto_err,
  output logic               data_err,
  output logic [CAP_P-1:0]   enq_cov,
  output logic [CAP_P-1:0]   deq_cov,
  output logic [CAP_P-2:0]   both_cov,
  output logic [15:0]        err_cnt
);

  localparam int unsigned PTR_W  = $clog2(CAP_P);
  localparam int unsigned CNT_W  = $clog2(CAP_P + 1);
  localparam int unsigned BOTH_W = CAP_P - 1;

  logic [WIDTH_P-1:0] mem [CAP_P];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               rst_q;

  logic enq_f, deq_f, full, empty, enq_ok, deq_ok, rv_bad;

  // Fire decode; the model only accepts events it can legally absorb.
  always_comb begin
    enq_f  = valid_i & ready_o;
    deq_f  = valid_o & yumi_i;
    full   = (count == CNT_W'(CAP_P));
    empty  = (count == '0);
    enq_ok = enq_f & ~full;
    deq_ok = deq_f & ~empty;
    rv_bad = (ready_o != ~full) | (valid_o != ~empty);
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      res_err   <= 1'b0;
      proto_err <= 1'b0;
      data_err  <= 1'b0;
    end else begin
      // First cycle out of reset checks the idle handshake instead of the model.
      res_err   <= rst_q & (~ready_o | valid_o);
      proto_err <= (~rst_q & rv_bad) | (enq_f & full) | (deq_f & empty);
      data_err  <= deq_ok & (data_o != mem[head]);
      if (enq_ok) tail <= tail + 1'b1;
      if (deq_ok) head <= head + 1'b1;
      count <= count + CNT_W'(enq_ok) - CNT_W'(deq_ok);
    end
  end

  // Storage needs no reset; stale contents are never read once count is zero.
  always_ff @(posedge clk) begin
    if (!rst && enq_ok) mem[tail] <= data_i;
  end

  // Coverage survives reset so a run can accumulate across reset tests.
  always_ff @(posedge clk) begin
    if (cov_clr) begin
      enq_cov  <= '0;
      deq_cov  <= '0;
      both_cov <= '0;
    end else if (!rst) begin
      if (enq_ok && !deq_ok) enq_cov  <= enq_cov  | (CAP_P'(1)  << count);
      if (deq_ok && !enq_ok) deq_cov  <= deq_cov  | (CAP_P'(1)  << (count - 1'b1));
      if (enq_ok && deq_ok)  both_cov <= both_cov | (BOTH_W'(1) << (count - 1'b1));
    end
  end

`ifdef FIFO_SCOREBOARD_ERR_CNT_EN
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, err_cnt} + 17'(res_err) + 17'(proto_err) + 17'(data_err);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench for fifo_scoreboard: a queue-based FIFO stand-in drives the tapped handshakes,
// optionally with injected faults, and a queue reference model predicts every output.
module tb_fifo_scoreboard;
  localparam int unsigned CAP = 8;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        yumi_i;
  logic        cov_clr;
  logic        res_err;
  logic        proto_err;
  logic        data_err;
  logic [7:0]  enq_cov;
  logic [7:0]  deq_cov;
  logic [6:0]  both_cov;
  logic [15:0] err_cnt;

  int compared   = 0;
  int mismatched = 0;

  // FIFO stand-in contents and reference-model contents
  byte unsigned fifo[$];
  byte unsigned ref_q[$];
  bit           m_rst_prev;
  bit           m_res, m_proto, m_data;
  bit [7:0]     m_enq, m_deq;
  bit [6:0]     m_both;
  int unsigned  m_cnt;

  fifo_scoreboard #(.WIDTH_P(8), .CAP_P(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i),
    .cov_clr  (cov_clr),
    .res_err  (res_err),
    .proto_err(proto_err),
    .data_err (data_err),
    .enq_cov  (enq_cov),
    .deq_cov  (deq_cov),
    .both_cov (both_cov),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict next-cycle outputs from the current inputs using the queue model.
  task automatic model_step();
    int          n;
    bit          first, enq_f, deq_f, enq_ok, deq_ok;
    int unsigned sum;
    sum = m_cnt + 32'(m_res) + 32'(m_proto) + 32'(m_data);
    if (rst) begin
      m_res = 1'b0; m_proto = 1'b0; m_data = 1'b0;
      m_cnt = 0;
      ref_q.delete();
    end else begin
      first  = m_rst_prev;
      n      = ref_q.size();
      enq_f  = valid_i && ready_o;
      deq_f  = valid_o && yumi_i;
      enq_ok = enq_f && (n < CAP);
      deq_ok = deq_f && (n > 0);
      m_res   = first && (!ready_o || valid_o);
      m_proto = (!first && ((ready_o != (n < CAP)) || (valid_o != (n > 0))))
                || (enq_f && n == CAP) || (deq_f && n == 0);
      m_data  = deq_ok && (data_o != ref_q[0]);
      m_cnt   = (sum > 65535) ? 65535 : sum;
      if (enq_ok && !deq_ok) m_enq[n] = 1'b1;
      if (deq_ok && !enq_ok) m_deq[n-1] = 1'b1;
      if (enq_ok && deq_ok)  m_both[n-1] = 1'b1;
      if (deq_ok) void'(ref_q.pop_front());
      if (enq_ok) ref_q.push_back(data_i);
    end
    if (cov_clr) begin
      m_enq = '0; m_deq = '0; m_both = '0;
    end
    m_rst_prev = rst;
  endtask

  // inj: 0 none, 1 flip ready, 2 flip valid, 3 corrupt data, 4 force valid, 5 force ready
  task automatic cycle(input bit vi, input bit [7:0] di, input bit yi, input int inj);
    int n;
    bit e, d;
    valid_i = vi;
    data_i  = di;
    yumi_i  = yi;
    ready_o = (fifo.size() < CAP);
    valid_o = (fifo.size() != 0);
    data_o  = valid_o ? fifo[0] : 8'h00;
    case (inj)
      1: ready_o = !ready_o;
      2: valid_o = !valid_o;
      3: data_o  = 8'hA5;
      4: valid_o = 1'b1;
      5: ready_o = 1'b1;
      default: ;
    endcase
    model_step();
    @(posedge clk);
    #1;
    chk("res_err",   16'(res_err),   16'(m_res));
    chk("proto_err", 16'(proto_err), 16'(m_proto));
    chk("data_err",  16'(data_err),  16'(m_data));
    chk("enq_cov",   16'(enq_cov),   16'(m_enq));
    chk("deq_cov",   16'(deq_cov),   16'(m_deq));
    chk("both_cov",  16'(both_cov),  16'(m_both));
`ifdef FIFO_SCOREBOARD_ERR_CNT_EN
    chk("err_cnt",   err_cnt,        16'(m_cnt));
`else
    chk("err_cnt",   err_cnt,        16'h0000);
`endif
    if (rst) begin
      fifo.delete();
    end else begin
      n = fifo.size();
      e = valid_i && ready_o && (n < CAP);
      d = valid_o && yumi_i && (n > 0);
      if (d) void'(fifo.pop_front());
      if (e) fifo.push_back(data_i);
    end
  endtask

  initial begin
    rst = 1'b1; cov_clr = 1'b1;
    valid_i = 1'b0; data_i = '0; ready_o = 1'b1; valid_o = 1'b0; data_o = '0; yumi_i = 1'b0;

    // Reset with coverage clear, then idle
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    rst = 1'b0; cov_clr = 1'b0;
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0);
    chk("idle_res_err", 16'(res_err), 16'h0);
    chk("idle_proto_err", 16'(proto_err), 16'h0);

    // Fill then drain
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
    chk("fill_enq_cov", 16'(enq_cov), 16'h00FF);
    chk("fill_deq_cov", 16'(deq_cov), 16'h00FF);
    chk("fill_both_cov", 16'(both_cov), 16'h0000);

    // Simultaneous enqueue and dequeue at occupancy 1..7
    for (int k = 1; k <= 7; k++) begin
      cycle(1, 8'($urandom), 0, 0);
      cycle(1, 8'($urandom), 1, 0);
    end
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
    chk("simul_both_cov", 16'(both_cov), 16'h007F);
    chk("simul_data_err", 16'(data_err), 16'h0);

    // Random legal traffic
    for (int i = 0; i < 300; i++) cycle(1'($urandom), 8'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);

    // Data corruption right after a fresh reset
    rst = 1'b1;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    rst = 1'b0;
    cycle(1, 8'h03, 0, 0);
    cycle(0, 8'h00, 1, 3);
    chk("corrupt_data_err", 16'(data_err), 16'h1);
    cycle(0, 8'h00, 0, 0);
    chk("corrupt_data_err_gone", 16'(data_err), 16'h0);
`ifdef FIFO_SCOREBOARD_ERR_CNT_EN
    chk("corrupt_err_cnt", err_cnt, 16'h0001);
`endif

    // Bad reset: valid held high in the first post-reset cycle
    rst = 1'b1;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    rst = 1'b0;
    cycle(0, 8'h00, 0, 4);
    chk("bad_reset_res_err", 16'(res_err), 16'h1);
    chk("bad_reset_proto_err", 16'(proto_err), 16'h0);
    cycle(0, 8'h00, 0, 0);
    chk("bad_reset_res_once", 16'(res_err), 16'h0);

    // Overflow: ready forced while model is full
    for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'h55, 0, 5);
    chk("overflow_proto_err", 16'(proto_err), 16'h1);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
    chk("overflow_data_err", 16'(data_err), 16'h0);

    // Reset mid-operation, then resume empty
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0);
    rst = 1'b1;
    cycle(0, 8'h00, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle(1'($urandom), 8'($urandom), 1'($urandom), 0);

    // Random traffic with fault injection, stray resets and coverage clears
    for (int i = 0; i < 400; i++) begin
      int inj;
      inj     = (($urandom % 8) == 0) ? int'($urandom_range(5, 1)) : 0;
      cov_clr = (($urandom % 50) == 0);
      rst     = (($urandom % 100) == 0);
      cycle(1'($urandom), 8'($urandom), 1'($urandom), inj);
    end
    rst = 1'b0; cov_clr = 1'b0;
    cycle(0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
